// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter : round-robin share of the register-file write port between
//                 two writeback sources, with a destination busy scoreboard.
// Revision      : 1.0
// ============================================================================
module rf_wb_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  output logic            hz_rs1,
  output logic            hz_rs2,
  input  logic            s0_valid,
  input  logic [4:0]      s0_rd,
  input  logic [XLEN-1:0] s0_data,
  output logic            s0_ready,
  input  logic            s1_valid,
  input  logic [4:0]      s1_rd,
  input  logic [XLEN-1:0] s1_data,
  output logic            s1_ready,
  output logic            we3,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3,
  output logic [31:0]     busy
);

  logic            r_last_s1;
  logic [31:0]     r_busy;
  logic            r_we;
  logic [4:0]      r_a3;
  logic [XLEN-1:0] r_wd;

  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_xfer;
  logic            w_wr;
  logic            w_iss;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_data;
  logic [31:0]     w_busy_nxt;

  always_comb begin
    // Grants are qualified by rst_n so nothing handshakes while in reset.
    w_gnt0     = rst_n & s0_valid & (~s1_valid | r_last_s1);
    w_gnt1     = rst_n & s1_valid & (~s0_valid | ~r_last_s1);
    w_xfer     = w_gnt0 | w_gnt1;
    w_rd       = w_gnt1 ? s1_rd   : s0_rd;
    w_data     = w_gnt1 ? s1_data : s0_data;
    w_wr       = w_xfer & (w_rd != 5'd0);
    w_iss      = rst_n & iss_valid & ((iss_rd == 5'd0) | ~r_busy[iss_rd]);
    w_busy_nxt = r_busy;
    if (w_wr)
      w_busy_nxt[w_rd] = 1'b0;
    // Issue is applied after the clear so a same-cycle set wins.
    if (w_iss)
      w_busy_nxt[iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_s1 <= 1'b1;
      r_busy    <= 32'd0;
      r_we      <= 1'b0;
      r_a3      <= 5'd0;
      r_wd      <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_we   <= w_wr;
      if (w_xfer)
        r_last_s1 <= w_gnt1;
      if (w_wr) begin
        r_a3 <= w_rd;
        r_wd <= w_data;
      end
    end
  end

  // A register stays hazardous until the write-stage cycle has committed it.
  always_comb begin
    hz_rs1 = (chk_rs1 != 5'd0) & (r_busy[chk_rs1] | (r_we & (r_a3 == chk_rs1)));
    hz_rs2 = (chk_rs2 != 5'd0) & (r_busy[chk_rs2] | (r_we & (r_a3 == chk_rs2)));
  end

  assign s0_ready  = w_gnt0;
  assign s1_ready  = w_gnt1;
  assign iss_ready = w_iss;
  assign we3       = r_we;
  assign a3        = r_a3;
  assign wd3       = r_wd;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_wb_arbiter : directed vector table, corner sequences and a randomized
//                    run against a behavioural model of the arbiter.
// Revision         : 1.0
// ============================================================================
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        hz_rs1;
  logic        hz_rs2;
  logic        s0_valid;
  logic [4:0]  s0_rd;
  logic [31:0] s0_data;
  logic        s0_ready;
  logic        s1_valid;
  logic [4:0]  s1_rd;
  logic [31:0] s1_data;
  logic        s1_ready;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] busy;

  int n_cmp = 0;
  int n_err = 0;

  rf_wb_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hz_rs1(hz_rs1), .hz_rs2(hz_rs2),
    .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_data(s1_data), .s1_ready(s1_ready),
    .we3(we3), .a3(a3), .wd3(wd3), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    s0_valid = 1'b0; s0_rd = 5'd0; s0_data = 32'd0;
    s1_valid = 1'b0; s1_rd = 5'd0; s1_data = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        v0; logic [4:0] rd0; logic [31:0] d0;
    logic        v1; logic [4:0] rd1; logic [31:0] d1;
    logic        e_r0; logic e_r1;
    logic        e_we; logic [4:0] e_a3; logic [31:0] e_wd;
  } vec_t;

  vec_t vt[10];

  // Behavioural model state
  logic [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  int          m_last;

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    vt[0] = '{1, 5'd1, 32'd1,          1, 5'd2, 32'd2,  1, 0, 0, 5'd0, 32'd0};
    vt[1] = '{1, 5'd1, 32'd1,          1, 5'd2, 32'd2,  0, 1, 1, 5'd1, 32'd1};
    vt[2] = '{1, 5'd1, 32'd1,          1, 5'd2, 32'd2,  1, 0, 1, 5'd2, 32'd2};
    vt[3] = '{1, 5'd1, 32'd1,          1, 5'd2, 32'd2,  0, 1, 1, 5'd1, 32'd1};
    vt[4] = '{1, 5'd5, 32'hDEADBEEF,   0, 5'd0, 32'd0,  1, 0, 1, 5'd2, 32'd2};
    vt[5] = '{0, 5'd0, 32'd0,          0, 5'd0, 32'd0,  0, 0, 1, 5'd5, 32'hDEADBEEF};
    vt[6] = '{1, 5'd0, 32'hFFFFFFFF,   0, 5'd0, 32'd0,  1, 0, 0, 5'd5, 32'hDEADBEEF};
    vt[7] = '{0, 5'd0, 32'd0,          0, 5'd0, 32'd0,  0, 0, 0, 5'd5, 32'hDEADBEEF};
    vt[8] = '{0, 5'd0, 32'd0,          1, 5'd3, 32'h33, 0, 1, 0, 5'd5, 32'hDEADBEEF};
    vt[9] = '{0, 5'd0, 32'd0,          0, 5'd0, 32'd0,  0, 0, 1, 5'd3, 32'h33};

    // Readies are forced low while in reset even with requests present.
    s0_valid = 1'b1; s1_valid = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
    #1;
    chk("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
    chk("rst_s1_ready", {31'd0, s1_ready}, 32'd0);
    chk("rst_iss_ready", {31'd0, iss_ready}, 32'd0);
    chk("rst_we3", {31'd0, we3}, 32'd0);
    chk("rst_a3", {27'd0, a3}, 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_busy", busy, 32'd0);
    do_reset();

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      s0_valid = vt[i].v0; s0_rd = vt[i].rd0; s0_data = vt[i].d0;
      s1_valid = vt[i].v1; s1_rd = vt[i].rd1; s1_data = vt[i].d1;
      #1;
      chk($sformatf("vec%0d_s0_ready", i), {31'd0, s0_ready}, {31'd0, vt[i].e_r0});
      chk($sformatf("vec%0d_s1_ready", i), {31'd0, s1_ready}, {31'd0, vt[i].e_r1});
      chk($sformatf("vec%0d_we3", i), {31'd0, we3}, {31'd0, vt[i].e_we});
      chk($sformatf("vec%0d_a3", i), {27'd0, a3}, {27'd0, vt[i].e_a3});
      chk($sformatf("vec%0d_wd3", i), wd3, vt[i].e_wd);
      chk($sformatf("vec%0d_busy", i), busy, 32'd0);
    end

    // ---------------- scoreboard / hazard sequence ----------------
    @(negedge clk); idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd7; #1;
    chk("iss7_ready", {31'd0, iss_ready}, 32'd1);
    @(negedge clk); chk_rs1 = 5'd7; #1;
    chk("busy7_set", busy, 32'h80);
    chk("iss7_waw_stall", {31'd0, iss_ready}, 32'd0);
    chk("hz7_busy", {31'd0, hz_rs1}, 32'd1);
    @(negedge clk); iss_valid = 1'b0;
    s1_valid = 1'b1; s1_rd = 5'd7; s1_data = 32'h77; #1;
    chk("wb7_s1_ready", {31'd0, s1_ready}, 32'd1);
    chk("wb7_hz_pre", {31'd0, hz_rs1}, 32'd1);
    @(negedge clk); s1_valid = 1'b0; #1;
    chk("busy7_clr", busy, 32'd0);
    chk("wb7_we3", {31'd0, we3}, 32'd1);
    chk("wb7_a3", {27'd0, a3}, 32'd7);
    chk("hz7_during_we3", {31'd0, hz_rs1}, 32'd1);
    @(negedge clk); #1;
    chk("hz7_after", {31'd0, hz_rs1}, 32'd0);

    // Issue to x0 is always accepted and never marks busy.
    @(negedge clk); chk_rs1 = 5'd0; iss_valid = 1'b1; iss_rd = 5'd0; #1;
    chk("iss0_ready", {31'd0, iss_ready}, 32'd1);
    @(negedge clk); iss_valid = 1'b0; #1;
    chk("iss0_busy", busy, 32'd0);

    // Same-cycle set and clear on rd 9: set wins.
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd9;
    s0_valid = 1'b1; s0_rd = 5'd9; s0_data = 32'h99; #1;
    chk("setwin_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("setwin_s0_ready", {31'd0, s0_ready}, 32'd1);
    @(negedge clk); idle_inputs(); #1;
    chk("setwin_busy", busy, 32'h200);

    // Reset mid-cycle while a request is present.
    @(negedge clk); iss_valid = 1'b1; iss_rd = 5'd3; #1;
    chk("rst_iss3_ready", {31'd0, iss_ready}, 32'd1);
    @(negedge clk); iss_valid = 1'b0;
    s1_valid = 1'b1; s1_rd = 5'd4; s1_data = 32'h44; #1;
    chk("rst_pre_busy", busy, 32'h208);
    chk("rst_pre_s1_ready", {31'd0, s1_ready}, 32'd1);
    #1 rst_n = 1'b0; #1;
    chk("midrst_s1_ready", {31'd0, s1_ready}, 32'd0);
    chk("midrst_busy", busy, 32'd0);
    chk("midrst_we3", {31'd0, we3}, 32'd0);
    @(negedge clk); idle_inputs(); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("postrst_we3", {31'd0, we3}, 32'd0);
    chk("postrst_busy", busy, 32'd0);

    // ---------------- randomized run against the model ----------------
    do_reset();
    m_busy = 32'd0; m_we = 1'b0; m_a3 = 5'd0; m_wd = 32'd0; m_last = 1;
    begin
      logic p0, p1, e_iss, e_hz1, e_hz2;
      int g;
      p0 = 1'b0; p1 = 1'b0;
      for (int c = 0; c < 600; c++) begin
        if (c > 0) @(negedge clk);
        if (!p0) begin
          s0_valid = ($urandom_range(0, 9) < 6); s0_rd = 5'($urandom_range(0, 7)); s0_data = $urandom;
        end
        if (!p1) begin
          s1_valid = ($urandom_range(0, 9) < 6); s1_rd = 5'($urandom_range(0, 7)); s1_data = $urandom;
        end
        iss_valid = ($urandom_range(0, 9) < 5);
        iss_rd    = 5'($urandom_range(0, 7));
        chk_rs1   = 5'($urandom_range(0, 7));
        chk_rs2   = 5'($urandom_range(0, 7));
        #1;
        if (s0_valid && !s1_valid)      g = 0;
        else if (s1_valid && !s0_valid) g = 1;
        else if (s0_valid && s1_valid)  g = (m_last == 0) ? 1 : 0;
        else                            g = -1;
        e_iss = iss_valid && (iss_rd == 5'd0 || !m_busy[iss_rd]);
        e_hz1 = (chk_rs1 != 5'd0) && (m_busy[chk_rs1] || (m_we && m_a3 == chk_rs1));
        e_hz2 = (chk_rs2 != 5'd0) && (m_busy[chk_rs2] || (m_we && m_a3 == chk_rs2));
        chk("rnd_s0_ready", {31'd0, s0_ready}, {31'd0, (g == 0)});
        chk("rnd_s1_ready", {31'd0, s1_ready}, {31'd0, (g == 1)});
        chk("rnd_iss_ready", {31'd0, iss_ready}, {31'd0, e_iss});
        chk("rnd_hz_rs1", {31'd0, hz_rs1}, {31'd0, e_hz1});
        chk("rnd_hz_rs2", {31'd0, hz_rs2}, {31'd0, e_hz2});
        chk("rnd_we3", {31'd0, we3}, {31'd0, m_we});
        chk("rnd_a3", {27'd0, a3}, {27'd0, m_a3});
        chk("rnd_wd3", wd3, m_wd);
        chk("rnd_busy", busy, m_busy);
        @(posedge clk);
        m_we = 1'b0;
        if (g >= 0) begin
          logic [4:0]  rd;
          logic [31:0] d;
          rd = (g == 0) ? s0_rd : s1_rd;
          d  = (g == 0) ? s0_data : s1_data;
          m_last = g;
          if (rd != 5'd0) begin
            m_we = 1'b1; m_a3 = rd; m_wd = d; m_busy[rd] = 1'b0;
          end
        end
        if (e_iss && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        p0 = s0_valid && (g != 0);
        p1 = s1_valid && (g != 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port (we3/a3/wd3) between two writeback sources: s0 (ALU path) and s1 (load/multi-cycle path). Round-robin arbitration on a valid/ready handshake, with a one-cycle registered write stage. Also maintains a busy scoreboard of destination registers with an outstanding writeback, and reports read-operand hazards to issue logic. Sits between the execute/memory units and the register file, alongside the issue stage.

Parameters:
XLEN, 32, data width of writeback data and wd3

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
iss_valid  input  1  issue stage requests to mark iss_rd pending
iss_rd  input  5  destination register of the issuing instruction
iss_ready  output  1  issue accepted this cycle
chk_rs1  input  5  source register 1 of the issuing instruction
chk_rs2  input  5  source register 2 of the issuing instruction
hz_rs1  output  1  chk_rs1 value not yet readable from the register file
hz_rs2  output  1  chk_rs2 value not yet readable from the register file
s0_valid  input  1  ALU writeback request
s0_rd  input  5  ALU destination register
s0_data  input  XLEN  ALU result
s0_ready  output  1  s0 granted this cycle
s1_valid  input  1  load/multi-cycle writeback request
s1_rd  input  5  load/multi-cycle destination register
s1_data  input  XLEN  load/multi-cycle result
s1_ready  output  1  s1 granted this cycle
we3  output  1  register file write enable (registered)
a3  output  5  register file write address (registered)
wd3  output  XLEN  register file write data (registered)
busy  output  32  scoreboard; bit n = register n has a writeback outstanding

Behaviour:
- Reset (async, rst_n=0): busy=0, we3=0, a3=0, wd3=0, last-grant pointer=s1. All readies forced 0 while rst_n=0. Reset mid-operation drops pending scoreboard state and any granted-but-unwritten data; no write occurs on the first edge after release.
- Arbitration (combinational, per cycle): at most one grant.
  - Only one valid: that source is granted.
  - Both valid: the source not granted last is granted.
  - Pointer updates only on a transfer.
- Transfer = sN_valid & sN_ready. Sources hold valid/rd/data stable until ready. Readies never depend on ready.
- Write stage: on a transfer with rd!=0, the next cycle has we3=1, a3=rd, wd3=data. Latency from transfer edge is one cycle, and the register file commits one edge later.
  - Otherwise the next cycle has we3=0, and a3/wd3 hold their last values.
  - Transfer with rd=0 is accepted (ready=1, pointer advances) and produces no write.
- Scoreboard: busy[0] is constant 0.
  - Issue: iss_ready = iss_valid & (iss_rd==0 | !busy[iss_rd]), which stalls WAW. On issue with iss_rd!=0, busy[iss_rd] is set at the edge.
  - Writeback: on a transfer with rd!=0, busy[rd] is cleared at the edge.
  - Same rd set and cleared in the same cycle: set wins.
  - Clearing a register that is not busy is harmless.
- Hazard (combinational): hz_rsN = (chk_rsN!=0) & (busy[chk_rsN] | (we3 & a3==chk_rsN)). The second term covers the cycle in which busy has cleared but the write has not yet committed. hz does not depend on iss_valid.
- Throughput: one write per cycle sustained. With both sources continuously valid, grants alternate s0,s1,s0,…

Test Plan:
- Reset then s0_valid=1, s0_rd=5, s0_data=32'hDEADBEEF -> s0_ready=1 that cycle; next cycle we3=1, a3=5, wd3=32'hDEADBEEF; the following cycle we3=0.
- Both valid from reset, s0_rd=1/data=1, s1_rd=2/data=2, held 4 cycles -> grants s0,s1,s0,s1; a3 sequence 1,2,1,2 one cycle behind.
- Issue iss_rd=7 -> busy[7]=1; second issue of rd 7 -> iss_ready=0; chk_rs1=7 -> hz_rs1=1. s1 writes rd 7 -> busy[7]=0 after the edge, hz_rs1 stays 1 during the we3 cycle and is 0 the cycle after.
- s0_rd=0, data=32'hFFFFFFFF -> s0_ready=1, we3 stays 0, busy unchanged; iss_rd=0 always gives iss_ready=iss_valid and never sets busy[0].
- Same cycle: issue rd 9 (busy[9]=0) and s0 writeback rd 9 -> busy[9]=1 after the edge (set wins).
- Issue rd 3, then assert rst_n=0 mid-cycle while s1_valid=1 -> readies=0 immediately, busy=0, we3=0; after release no spurious write.
